// File: rtl/dds_phase_reader.sv
// DDS phase accumulator driving the waveform RAM read port.
// Realigns registered RAM data into a valid-qualified sample stream.
module dds_phase_reader #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   burst_mode,
  input  logic [15:0]            burst_len,
  input  logic [PHASE_WIDTH-1:0] poff_in,
  input  logic [PHASE_WIDTH-1:0] ftw_in,
  input  logic                   ftw_valid,
  output logic                   ftw_ready,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  input  logic [DATA_WIDTH-1:0]  ram_dout,
  output logic [DATA_WIDTH-1:0]  sample_out,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam int FW = $clog2(RAM_LATENCY + 1) + 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(RAM_LATENCY);

  logic [1:0]             state;
  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] ftw_active;
  logic [PHASE_WIDTH-1:0] ftw_pend;
  logic                   pend_valid;
  logic                   mode_q;
  logic [15:0]            len_q;
  logic [15:0]            cnt;
  logic [FW-1:0]          fcnt;
  logic [RAM_LATENCY:0]   dly;

  logic [PHASE_WIDTH:0]   step;
  logic                   carry;
  logic [16:0]            eff_len;
  logic                   last_issue;
  logic                   run;
  logic                   flush_end;
  logic                   accept;

  assign step  = {1'b0, phase} + {1'b0, ftw_active};
  assign carry = step[PHASE_WIDTH];

  // a zero burst length still issues one address
  assign eff_len = (len_q == 16'd0) ? 17'd1 : {1'b0, len_q};

  assign last_issue = mode_q ? (({1'b0, cnt} + 17'd1) >= eff_len)
                             : stop;

  assign run       = (state == S_RUN);
  assign flush_end = (state == S_FLUSH) && (fcnt == FLUSH_LAST);
  assign ftw_ready = !pend_valid;
  assign accept    = ftw_valid && ftw_ready;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= '0;
      cnt      <= '0;
      fcnt     <= '0;
      mode_q   <= 1'b0;
      len_q    <= '0;
      ram_addr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            phase  <= '0;
            mode_q <= burst_mode;
            len_q  <= burst_len;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          ram_addr <= ADDR_WIDTH'((phase + poff_in)
                      >> (PHASE_WIDTH - ADDR_WIDTH));
          phase    <= step[PHASE_WIDTH-1:0];
          cnt      <= cnt + 16'd1;
          if (last_issue) begin
            state <= S_FLUSH;
            fcnt  <= '0;
          end
        end
        S_FLUSH: begin
          fcnt <= fcnt + 1'b1;
          if (flush_end) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // new words wait for a phase wrap so the output stays continuous
  always_ff @(posedge clk) begin
    if (rst) begin
      ftw_active <= '0;
      ftw_pend   <= '0;
      pend_valid <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept) ftw_active <= ftw_in;
    end else if (flush_end) begin
      if (pend_valid) ftw_active <= ftw_pend;
      if (accept) ftw_active <= ftw_in;
      pend_valid <= 1'b0;
    end else begin
      if (run && carry && pend_valid) begin
        ftw_active <= ftw_pend;
        pend_valid <= 1'b0;
      end
      if (accept) begin
        ftw_pend   <= ftw_in;
        pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly          <= '0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
      done         <= 1'b0;
    end else begin
      dly[0] <= run;
      for (int i = 1; i <= RAM_LATENCY; i++) begin
        dly[i] <= dly[i-1];
      end
      sample_valid <= dly[RAM_LATENCY];
      if (dly[RAM_LATENCY]) sample_out <= ram_dout;
      done <= flush_end;
    end
  end

endmodule

// File: tb/tb_dds_phase_reader.sv
// Bench for dds_phase_reader: phase-level model plus directed vectors.
// RAM holds mem[i]=i with one cycle of read latency.
module tb_dds_phase_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        burst_mode;
  logic [15:0] burst_len;
  logic [31:0] poff_in;
  logic [31:0] ftw_in;
  logic        ftw_valid;
  logic        ftw_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_dout = '0;
  logic [31:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  dds_phase_reader dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .burst_mode(burst_mode),
    .burst_len(burst_len),
    .poff_in(poff_in),
    .ftw_in(ftw_in),
    .ftw_valid(ftw_valid),
    .ftw_ready(ftw_ready),
    .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .busy(busy),
    .done(done)
  );

  logic [31:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
  always @(posedge clk) ram_dout <= mem[ram_addr];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  bit armed = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int want[$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, req);
    end
  endtask

  // expected samples from phase arithmetic; a word accepted at
  // issue index acc takes effect at the first later wrap
  task automatic model_push(input logic [31:0] ftw0,
                            input logic [31:0] ftw1,
                            input int acc,
                            input logic [31:0] poff,
                            input int n);
    longint unsigned ph = 0;
    longint unsigned f = ftw0;
    longint unsigned m = 64'h1_0000_0000;
    bit pend = 1'b0;
    int a;
    for (int k = 0; k < n; k++) begin
      a = int'(((ph + poff) % m) >> 22);
      exp_q.push_back(mem[a]);
      if (pend && (ph + f >= m)) begin
        ph = ph + f - m;
        f = ftw1;
        pend = 1'b0;
      end else begin
        ph = (ph + f) % m;
      end
      if (k == acc) pend = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (sample_valid) begin
        got_q.push_back(sample_out);
        chk("sample_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0)
          chk("sample", sample_out, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("done_with_last_valid", 32'(sample_valid), 1);
        chk("done_queue_empty", 32'(exp_q.size()), 0);
      end
    end
  end

  task automatic chk_list(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++)
      if (i < got_q.size()) chk(name, got_q[i], 32'(want[i]));
    got_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ftw(input logic [31:0] v);
    ftw_in = v;
    ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 1);
    chk("busy_low_at_done", 32'(busy), 0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    burst_mode = 1'b0;
    burst_len = '0;
    poff_in = '0;
    ftw_in = '0;
    ftw_valid = 1'b0;
    repeat (3) tick();
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_sample_valid", 32'(sample_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ftw_ready", 32'(ftw_ready), 1);
    rst = 1'b0;
    armed = 1'b1;
    tick();

    load_ftw(32'h0040_0000);
    burst_mode = 1'b1;
    burst_len = 16'd4;
    model_push(32'h0040_0000, 0, -1, poff_in, 4);
    pulse_start();
    wait_done(40);
    want = '{0, 1, 2, 3};
    chk_list("burst4");

    poff_in = 32'(5) << 22;
    model_push(32'h0040_0000, 0, -1, poff_in, 4);
    pulse_start();
    wait_done(40);
    want = '{5, 6, 7, 8};
    chk_list("burst_poff5");

    poff_in = 32'(1020) << 22;
    burst_len = 16'd6;
    model_push(32'h0040_0000, 0, -1, poff_in, 6);
    pulse_start();
    wait_done(40);
    want = '{1020, 1021, 1022, 1023, 0, 1};
    chk_list("burst_wrap");

    load_ftw(32'h8000_0000);
    poff_in = '0;
    burst_mode = 1'b0;
    d0 = done_cnt;
    model_push(32'h8000_0000, 0, -1, 0, 5);
    pulse_start();
    repeat (4) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(40);
    want = '{0, 512, 0, 512, 0};
    chk_list("cont_half");
    chk("cont_done_pulses", 32'(done_cnt - d0), 1);

    load_ftw(32'h4000_0000);
    model_push(32'h4000_0000, 32'h0040_0000, 1, 0, 7);
    pulse_start();
    tick();
    ftw_in = 32'h0040_0000;
    ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    chk("ftw_ready_pending", 32'(ftw_ready), 0);
    tick();
    chk("ftw_ready_pending2", 32'(ftw_ready), 0);
    chk("ftw_addr512", 32'(ram_addr), 512);
    tick();
    chk("ftw_ready_after_carry", 32'(ftw_ready), 1);
    chk("ftw_addr768", 32'(ram_addr), 768);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(40);
    want = '{0, 256, 512, 768, 0, 1, 2};
    chk_list("ftw_update");

    load_ftw(32'h0040_0000);
    burst_mode = 1'b1;
    burst_len = 16'd100;
    model_push(32'h0040_0000, 0, -1, 0, 2);
    pulse_start();
    ftw_in = 32'h0200_0000;
    ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    chk("rst_test_pending", 32'(ftw_ready), 0);
    tick();
    tick();
    tick();
    chk("rst_test_addr3", 32'(ram_addr), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(sample_valid), 0);
    chk("mid_rst_addr", 32'(ram_addr), 0);
    chk("mid_rst_ftw_ready", 32'(ftw_ready), 1);
    chk("mid_rst_done", 32'(done), 0);
    tick();
    tick();
    chk("mid_rst_queue", 32'(exp_q.size()), 0);
    want = '{0, 1};
    chk_list("pre_rst");

    burst_len = 16'd3;
    model_push(0, 0, -1, 0, 3);
    pulse_start();
    wait_done(40);
    want = '{0, 0, 0};
    chk_list("zero_ftw");

    load_ftw(32'h0040_0000);
    poff_in = 32'(7) << 22;
    burst_len = 16'd0;
    d0 = done_cnt;
    model_push(32'h0040_0000, 0, -1, poff_in, 1);
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_flush_busy", 32'(busy), 1);
    wait_done(40);
    repeat (4) tick();
    chk("len0_idle", 32'(busy), 0);
    chk("len0_done_pulses", 32'(done_cnt - d0), 1);
    want = '{7};
    chk_list("len0");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dds_phase_reader.md
Name: dds_phase_reader

Overview:
- DDS front end that generates phase and drives the read port of the dual-port waveform RAM.
- Accumulates a frequency tuning word (FTW) and issues table addresses to the RAM read port (port B; write enable tied low).
- Realigns the RAM's registered read data into a sample stream with a valid flag.
- Supports continuous and burst operation, a phase offset, and phase-continuous FTW updates via valid/ready.

Parameters:
- PHASE_WIDTH, 32, phase accumulator width.
- ADDR_WIDTH, 10, RAM address width. Must satisfy ADDR_WIDTH <= PHASE_WIDTH.
- DATA_WIDTH, 32, RAM data and sample width.
- RAM_LATENCY, 1, cycles from a ram_addr change to valid ram_dout.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins generation when IDLE.
- stop  in  1  one-cycle pulse; ends continuous generation.
- burst_mode  in  1  1 = burst of burst_len samples, 0 = continuous. Latched on start.
- burst_len  in  16  sample count for burst mode. Latched on start.
- poff_in  in  PHASE_WIDTH  phase offset. Sampled every cycle.
- ftw_in  in  PHASE_WIDTH  new tuning word.
- ftw_valid  in  1  ftw_in valid.
- ftw_ready  out  1  FTW can be accepted.
- ram_addr  out  ADDR_WIDTH  to RAM addrb.
- ram_dout  in  DATA_WIDTH  from RAM doutb.
- sample_out  out  DATA_WIDTH  registered waveform sample.
- sample_valid  out  1  sample_out valid this cycle.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse at the end of generation.

Behaviour:
- Reset values:
  - All outputs 0, except ftw_ready = 1.
  - Internal state: phase, ftw_active and pending FTW all 0; state = IDLE.
  - Reset mid-operation aborts immediately; any pending FTW is discarded.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on start. On that edge: phase <= 0; latch burst_mode and burst_len; clear the sample counter.
  - RUN, every cycle:
    - ram_addr <= (phase + poff_in)[PHASE_WIDTH-1 -: ADDR_WIDTH], i.e. top bits, modulo 2^PHASE_WIDTH.
    - phase <= phase + ftw_active (wraps).
    - Sample counter increments.
  - RUN -> FLUSH when either:
    - burst mode and this cycle issues the burst_len-th address; or
    - continuous mode and stop is high. The address for that cycle is still issued.
  - burst_len = 0 in burst mode: RUN lasts exactly one cycle and issues one address (treated as 1).
  - FLUSH lasts RAM_LATENCY+1 cycles, then goes to IDLE. done pulses on the edge entering IDLE.
  - start while busy: ignored. stop in IDLE or FLUSH: ignored.
- Sample path:
  - A delay line of RAM_LATENCY+1 stages carries the address-issued flag.
  - sample_out <= ram_dout when the delayed flag's final stage is set; sample_valid mirrors that stage.
  - Latency: sample_valid rises RAM_LATENCY+1 cycles after the matching ram_addr.
  - With RAM_LATENCY=1, the first sample_valid is 3 edges after the start-sampling edge.
  - done coincides with the last sample_valid.
  - sample_out holds its value when sample_valid is low.
- FTW handshake (accept on ftw_valid && ftw_ready):
  - IDLE: ftw_ready = 1; ftw_active <= ftw_in directly.
  - RUN/FLUSH: an accepted word goes to a pending register, and ftw_ready = 0 while a word is pending.
  - The pending word moves to ftw_active on the edge where phase + ftw_active carries out of PHASE_WIDTH.
  - The carrying step itself still uses the old word, so the phase stays continuous. ftw_ready returns to 1 on the next cycle.
  - Pending at the entry to IDLE: applied on that edge.
  - Simultaneous carry and new accept: the existing pending word is applied first; the new word becomes pending.

Test Plan:
- RAM preloaded with mem[i]=i, ftw=2^22, poff=0, burst_mode=1, burst_len=4, start -> ram_addr 0,1,2,3; sample_out 0,1,2,3 on 4 consecutive sample_valid cycles; done with sample 3; busy low afterwards.
- poff=5*2^22, same burst -> samples 5,6,7,8. Then poff=1020*2^22, burst_len=6 -> samples 1020,1021,1022,1023,0,1 (address wrap).
- Continuous mode, ftw=2^31, stop after 5 RUN cycles -> addresses 0,512,0,512,0; exactly 5 sample_valid pulses; done on the fifth.
- Continuous mode, ftw=2^30; present ftw_in=2^22 during the cycle issuing address 256 -> ftw_ready low; addresses 256,512,768,0,1,2; ftw_ready high again after the carry.
- Assert rst during RUN at address 3 -> next cycle: busy=0, sample_valid=0, ram_addr=0, ftw_ready=1. After reset, start without loading an FTW -> addresses stay 0 (ftw_active = 0).
- burst_len=0, then a start pulse during FLUSH -> exactly one sample; the second start is ignored; one done pulse.
